// File: rtl/branch_cond_pkg.sv
// branch_cond_pkg: condition codes, FSM encoding and operand-class helper for branch_cond_unit
package branch_cond_pkg;
  localparam logic [2:0] BRZR = 3'b000;
  localparam logic [2:0] BRNZ = 3'b001;
  localparam logic [2:0] BRPL = 3'b010;
  localparam logic [2:0] BRMI = 3'b011;
  localparam logic [2:0] BREQ = 3'b100;
  localparam logic [2:0] BRNE = 3'b101;
  localparam logic [2:0] BRLT = 3'b110;
  localparam logic [2:0] BRGE = 3'b111;
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;
  function automatic logic is_two_operand(input logic [2:0] code);
    return code[2];
  endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational branch condition evaluator (code, a, b -> result); odd codes invert their even partner
module cond_eval #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            code,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  result
);
  logic base;
  assign base = code[2] ? (code[1] ? ($signed(a) < $signed(b)) : (a == b))
                        : (code[1] ? ~b[DATA_WIDTH-1] : (b == '0));
  assign result = base ^ code[0];
endmodule

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: registered CON decision with operand-A FSM, error pulse and saturating taken counter (clk, rst, ir_in, bus_in, cmp_a_in, con_in -> con_out, con_valid, a_held, cond_err, taken_count)
module branch_cond_unit
  import branch_cond_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IR_WIDTH   = 32,
  parameter int C2_LSB     = 19,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IR_WIDTH-1:0]   ir_in,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  cmp_a_in,
  input  logic                  con_in,
  output logic                  con_out,
  output logic                  con_valid,
  output logic                  a_held,
  output logic                  cond_err,
  output logic [CNT_WIDTH-1:0]  taken_count
);
  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic                  con_q, valid_q, err_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]            code;
  logic                  two, err, res, taken;
  logic                  unused_ir;
  assign unused_ir = ^ir_in;
  assign code  = ir_in[C2_LSB +: 3];
  assign two   = is_two_operand(code);
  assign err   = two && state_q == IDLE;
  assign taken = res && !err;
  assign cnt_d = (taken && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  cond_eval #(.DATA_WIDTH(DATA_WIDTH)) u_eval (
    .code  (code),
    .a     (a_q),
    .b     (bus_in),
    .result(res)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      con_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= con_in;
      err_q   <= con_in && err;
      if (con_in) begin
        con_q <= taken;
        cnt_q <= cnt_d;
        if (two) state_q <= IDLE;
      end else if (cmp_a_in) begin
        a_q     <= bus_in;
        state_q <= HELD;
      end
    end
  end
  assign con_out     = con_q;
  assign con_valid   = valid_q;
  assign cond_err    = err_q;
  assign a_held      = state_q == HELD;
  assign taken_count = cnt_q;
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed scoreboard bench for branch_cond_unit (16-bit and 2-bit counter instances)
module tb_branch_cond_unit;
  import branch_cond_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] ir_in = '0;
  logic [31:0] bus_in = '0;
  logic cmp_a_in = 1'b0;
  logic con_in = 1'b0;
  logic con_out, con_valid, a_held, cond_err;
  logic [15:0] taken_count;
  logic con_out_s, con_valid_s, a_held_s, cond_err_s;
  logic [1:0] taken_count_s;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic        con;
    logic        err;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
    logic        held;
  } exp_t;
  exp_t q[$];
  logic        m_held = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt_s = '0;
  always #5 clk = ~clk;
  branch_cond_unit dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .bus_in(bus_in), .cmp_a_in(cmp_a_in), .con_in(con_in),
    .con_out(con_out), .con_valid(con_valid), .a_held(a_held), .cond_err(cond_err), .taken_count(taken_count)
  );
  branch_cond_unit #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .ir_in(ir_in), .bus_in(bus_in), .cmp_a_in(cmp_a_in), .con_in(con_in),
    .con_out(con_out_s), .con_valid(con_valid_s), .a_held(a_held_s), .cond_err(cond_err_s), .taken_count(taken_count_s)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic op(input logic c, input logic m, input logic [2:0] code, input logic [31:0] bus,
                    input logic e_con, input logic e_err);
    logic [31:0] t;
    @(negedge clk);
    t = $urandom;
    t[21:19] = code;
    ir_in = t;
    bus_in = bus;
    con_in = c;
    cmp_a_in = m;
    if (c) begin
      if (e_con) begin
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (m_cnt_s != 2'd3) m_cnt_s++;
      end
      if (code[2]) m_held = 1'b0;
      q.push_back('{e_con, e_err, m_cnt, m_cnt_s, m_held});
    end else if (m) m_held = 1'b1;
  endtask
  task automatic idle();
    @(negedge clk);
    con_in = 1'b0;
    cmp_a_in = 1'b0;
    bus_in = $urandom;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    con_in = 1'b0;
    cmp_a_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_held = 1'b0;
    m_cnt = '0;
    m_cnt_s = '0;
  endtask
  always @(negedge clk) begin
    if (!rst && (con_valid || cond_err || con_valid_s || cond_err_s)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got con_valid=%0b cond_err=%0b with nothing pending at %0t", con_valid, cond_err, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("con_valid", 32'(con_valid), 32'd1);
        chk("con_out", 32'(con_out), 32'(e.con));
        chk("cond_err", 32'(cond_err), 32'(e.err));
        chk("taken_count", 32'(taken_count), 32'(e.cnt));
        chk("a_held", 32'(a_held), 32'(e.held));
        chk("con_out_small", 32'(con_out_s), 32'(e.con));
        chk("taken_count_small", 32'(taken_count_s), 32'(e.cnt_s));
      end
    end
  end
  initial begin
    do_reset();
    chk("rst_con_out", 32'(con_out), 32'd0);
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_cond_err", 32'(cond_err), 32'd0);
    chk("rst_a_held", 32'(a_held), 32'd0);
    chk("rst_taken_count", 32'(taken_count), 32'd0);
    op(1, 0, BRZR, 32'h0, 1, 0);
    op(1, 0, BRZR, 32'h5, 0, 0);
    op(1, 0, BRPL, 32'h8000_0000, 0, 0);
    op(1, 0, BRMI, 32'h8000_0000, 1, 0);
    op(1, 0, BRPL, 32'h0, 1, 0);
    op(1, 0, BRMI, 32'h0, 0, 0);
    op(1, 0, BRNZ, 32'h5, 1, 0);
    idle();
    chk("con_out_holds", 32'(con_out), 32'd1);
    op(0, 1, BRZR, 32'hFFFF_FFFE, 0, 0);
    idle();
    chk("a_held_after_cmp", 32'(a_held), 32'd1);
    op(1, 0, BRLT, 32'h3, 1, 0);
    op(0, 1, BRZR, 32'hFFFF_FFFE, 0, 0);
    op(1, 0, BRGE, 32'h3, 0, 0);
    op(0, 1, BRZR, 32'h5, 0, 0);
    op(1, 0, BRLT, 32'hFFFF_FFFF, 0, 0);
    op(0, 1, BRZR, 32'h4, 0, 0);
    op(1, 0, BRNE, 32'h4, 0, 0);
    op(0, 1, BRZR, 32'h4, 0, 0);
    op(1, 0, BREQ, 32'h4, 1, 0);
    op(1, 0, BREQ, 32'h0, 0, 1);
    idle();
    idle();
    chk("err_one_cycle", 32'(cond_err), 32'd0);
    op(0, 1, BRZR, 32'h9, 0, 0);
    op(1, 1, BRNZ, 32'hA, 1, 0);
    op(1, 1, BREQ, 32'h9, 1, 0);
    op(0, 1, BRZR, 32'h7, 0, 0);
    idle();
    chk("a_held_before_rst", 32'(a_held), 32'd1);
    do_reset();
    chk("a_held_after_rst", 32'(a_held), 32'd0);
    chk("count_after_rst", 32'(taken_count), 32'd0);
    op(1, 0, BREQ, 32'h7, 0, 1);
    op(1, 0, BRZR, 32'h0, 1, 0);
    op(1, 0, BRZR, 32'h0, 1, 0);
    op(1, 0, BRZR, 32'h0, 1, 0);
    op(1, 0, BRZR, 32'h0, 1, 0);
    op(1, 0, BRZR, 32'h0, 1, 0);
    idle();
    idle();
    idle();
    chk("small_saturated", 32'(taken_count_s), 32'd3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
